// File: rtl/obuf2ddr_pkg.sv
// obuf2ddr shared definitions: DDR word width, default element width,
// bit-width helper and the streamer FSM state type.
package obuf2ddr_pkg;

    localparam int DDR_W      = 512;
    localparam int DEF_DATA_W = 64;

    function automatic int bw(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

endpackage

// File: rtl/obuf2ddr.sv
// obuf2ddr: reads num buffer elements and packs BATCH of them per DDR word,
// streaming words out on a valid/ready channel; pulses done when finished.
module obuf2ddr
    import obuf2ddr_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BUF_DEPTH = 256,
    parameter int ADDR_W    = bw(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [7:0]        num,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              buf_rd_en,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic [DDR_W-1:0]  ddr_data,
    output logic              ddr_valid,
    input  logic              ddr_ready
);

    localparam int BATCH = DDR_W / DATA_W;
    localparam int CNT_W = $clog2(BATCH + 1);

    state_t             r_state;
    logic [7:0]         r_num;
    logic [8:0]         r_rd_cnt;
    logic [8:0]         r_rcv;
    logic               r_inflight;
    logic [CNT_W-1:0]   r_pack_cnt;
    logic [DDR_W-1:0]   r_pack;
    logic [DDR_W-1:0]   r_out;
    logic               r_valid;
    logic               r_done;

    logic [CNT_W-1:0]   w_m;
    logic [8:0]         w_rcv_n;
    logic [8:0]         w_num9;
    logic [DDR_W-1:0]   w_merge;
    logic               w_cmpl;
    logic               w_xfer;
    logic               w_issue;
    logic               w_fin;

    // Pack contents as they will be once this cycle's returning element lands.
    always_comb begin
        w_merge = r_pack;
        if (r_inflight) begin
            w_merge[int'(r_pack_cnt)*DATA_W +: DATA_W] = buf_rd_data;
        end
    end

    assign w_num9  = {1'b0, r_num};
    assign w_m     = r_pack_cnt + CNT_W'(r_inflight);
    assign w_rcv_n = r_rcv + 9'(r_inflight);

    // The word is complete when full or when it holds the final element;
    // folding the arriving element in lets it move to out in the same cycle.
    assign w_cmpl = (w_m != '0) &&
                    ((w_m == CNT_W'(BATCH)) || (w_rcv_n == w_num9));
    assign w_xfer = w_cmpl && (!r_valid || ddr_ready);

    // A read is allowed while its data has a free lane to land in,
    // counting the lanes freed by a transfer happening this cycle.
    assign w_issue = (r_state == S_RUN) && (r_rd_cnt < w_num9) &&
                     ((w_m < CNT_W'(BATCH)) || w_xfer);

    assign w_fin = (r_state == S_FLUSH) && (r_rcv == w_num9) &&
                   !r_inflight && (r_pack_cnt == '0) &&
                   (!r_valid || ddr_ready);

    assign buf_rd_en   = w_issue;
    assign buf_rd_addr = ADDR_W'(r_rd_cnt);
    assign ddr_data    = r_out;
    assign ddr_valid   = r_valid;
    assign done        = r_done;

    // Control FSM with read/receive counters and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_rd_cnt   <= '0;
            r_rcv      <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (r_inflight) r_rcv <= r_rcv + 9'd1;
            if (w_issue) r_rd_cnt <= r_rd_cnt + 9'd1;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num    <= num;
                        r_rd_cnt <= '0;
                        r_rcv    <= '0;
                        r_state  <= (num != 8'd0) ? S_RUN : S_FLUSH;
                    end
                end
                S_RUN: begin
                    if (w_issue && ((r_rd_cnt + 9'd1) == w_num9))
                        r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (w_fin) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pack/out double register: fill pack, hand complete words to out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack     <= '0;
            r_pack_cnt <= '0;
            r_out      <= '0;
            r_valid    <= 1'b0;
        end else if (w_xfer) begin
            r_out      <= w_merge;
            r_valid    <= 1'b1;
            r_pack     <= '0;
            r_pack_cnt <= '0;
        end else begin
            if (r_valid && ddr_ready) r_valid <= 1'b0;
            r_pack     <= w_merge;
            r_pack_cnt <= w_m;
        end
    end

endmodule
